pwm_decoder: RTL and testbench

Receive-side counterpart of the falling-edge-driven PWM generator. Samples an asynchronous PWM waveform, aligns to its rising edges, and measures each period's total length and high time. Reports the recovered 8-bit duty value, the period length, lock status and a stuck-line flag. Sits at the board input that faces a remote PWM generator of the same frame format, where the frame is 256 clocks.

---
 rtl/pwm_decoder.sv | 119 +++++++++++
 tb/tb_pwm_decoder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers duty and period from an asynchronous PWM line.
// Reports on each rising edge once phase-aligned, or on a stuck-line timeout.
module pwm_decoder #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = (1 << (WIDTH + 1)) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH:0]   period,
  output logic             valid,
  output logic             locked,
  output logic             stuck
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  localparam logic [WIDTH:0]   TMO  = (WIDTH + 1)'(TIMEOUT);
  localparam logic [WIDTH:0]   ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DMAX = {WIDTH{1'b1}};

  logic s1_q, s_q, sd_q;
  logic rise;

  state_e           state_q, state_d;
  logic [WIDTH:0]   pcnt_q, pcnt_d;
  logic [WIDTH:0]   hcnt_q, hcnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             stuck_q, stuck_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s_q  <= s1_q;
      sd_q <= s_q;
    end
  end

  assign rise = s_q & ~sd_q;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q + ONE;
    hcnt_d   = hcnt_q + {{WIDTH{1'b0}}, s_q};
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    stuck_d  = stuck_q;
    unique case (1'b1)
      rise && (state_q == MEASURE): begin
        valid_d  = 1'b1;
        period_d = pcnt_q;
        duty_d   = hcnt_q[WIDTH] ? DMAX : hcnt_q[WIDTH-1:0];
        locked_d = 1'b1;
        stuck_d  = 1'b0;
        pcnt_d   = ONE;
        hcnt_d   = ONE;
      end
      rise && (state_q == IDLE): begin
        state_d = MEASURE;
        stuck_d = 1'b0;
        pcnt_d  = ONE;
        hcnt_d  = ONE;
      end
      !rise && (pcnt_q == TMO): begin
        valid_d  = 1'b1;
        duty_d   = s_q ? DMAX : '0;
        period_d = '0;
        stuck_d  = 1'b1;
        locked_d = 1'b0;
        state_d  = IDLE;
        pcnt_d   = '0;
        hcnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      stuck_q  <= stuck_d;
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign locked = locked_q;
  assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: drives waveforms and compares every cycle against a
// timestamp-based reference (periods from rise times, duty from sample sums).
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] duty;
  logic [8:0] period;
  logic       valid, locked, stuck;

  pwm_decoder dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty(duty), .period(period), .valid(valid),
    .locked(locked), .stuck(stuck)
  );

  always #5 clk = ~clk;

  wire [19:0] obs = {valid, locked, stuck, duty, period};

  int n_chk = 0;
  int n_fail = 0;

  bit   inb [0:65535];
  int   m;
  int   last_rise;
  bit   have_ref;
  int   deadline;
  logic e_valid, e_locked, e_stuck;
  logic [7:0]  e_duty;
  logic [8:0]  e_period;
  logic [19:0] exp_v;
  bit   wq[$];

  function automatic bit inv(input int i);
    return (i < 1) ? 1'b0 : inb[i];
  endfunction

  task automatic model_reset();
    m = 0; have_ref = 0; deadline = 512; last_rise = 0;
    e_valid = 0; e_locked = 0; e_stuck = 0;
    e_duty = 0; e_period = 0;
    exp_v = '0;
  endtask

  // Input sample i is seen by the decoder as a rise at edge i+2.
  task automatic model_edge();
    bit r;
    int i;
    int h;
    r = inv(m - 2) && !inv(m - 3);
    e_valid = 0;
    if (r) begin
      i = m - 2;
      if (have_ref) begin
        h = 0;
        for (int j = last_rise; j < i; j++) h += inb[j];
        e_valid = 1;
        e_period = 9'(i - last_rise);
        e_duty = (h > 255) ? 8'd255 : 8'(h);
        e_locked = 1;
      end
      e_stuck = 0; have_ref = 1; last_rise = i;
      deadline = m + 511;
    end else if (m == deadline) begin
      e_valid = 1;
      e_duty = inv(m - 2) ? 8'd255 : 8'd0;
      e_period = 0; e_stuck = 1; e_locked = 0;
      have_ref = 0; deadline = m + 512;
    end
    exp_v = {e_valid, e_locked, e_stuck, e_duty, e_period};
  endtask

  task automatic tick(input bit v);
    pwm_in = v;
    m++;
    inb[m] = v;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic do_reset();
    pwm_in = 0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    model_reset();
  endtask

  task automatic seg(input bit v, input int n);
    for (int k = 0; k < n; k++) wq.push_back(v);
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_vals got %h exp %h", obs, 20'h0);
    end
    rst = 1;
    model_reset();
    seg(0, 20);
    while (wq.size() > 0) begin
      tick(wq.pop_front());
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_idle m=%0d got %h exp %h", m, obs, exp_v);
      end
    end
  endtask

  task automatic test_nominal();
    int hits = 0;
    do_reset();
    seg(0, 5);
    for (int f = 0; f < 3; f++) begin seg(1, 100); seg(0, 156); end
    while (wq.size() > 0) begin
      tick(wq.pop_front());
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL nominal m=%0d got %h exp %h", m, obs, exp_v);
      end
      if (valid && duty == 100 && period == 256 && locked && !stuck)
        hits++;
    end
    n_chk++;
    if (hits !== 2) begin
      n_fail++;
      $display("FAIL nominal_reports got %0d exp 2", hits);
    end
  endtask

  task automatic test_stuck_low();
    int nv = 0;
    int first = -1;
    do_reset();
    seg(0, 1100);
    while (wq.size() > 0) begin
      tick(wq.pop_front());
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL stuck_low m=%0d got %h exp %h", m, obs, exp_v);
      end
      if (valid) begin
        nv++;
        if (first < 0) first = m;
        n_chk++;
        if ({locked, stuck, duty, period} !== {2'b01, 8'd0, 9'd0}) begin
          n_fail++;
          $display("FAIL stuck_low_rep m=%0d got %h", m, obs);
        end
      end
    end
    n_chk++;
    if (nv !== 2 || first !== 512) begin
      n_fail++;
      $display("FAIL stuck_low_cnt got %0d@%0d exp 2@512", nv, first);
    end
  endtask

  task automatic test_stuck_high();
    bit saw = 0;
    logic [19:0] last = '0;
    do_reset();
    seg(0, 3); seg(1, 600); seg(0, 7);
    for (int f = 0; f < 2; f++) begin seg(1, 3); seg(0, 7); end
    seg(1, 3); seg(0, 4);
    while (wq.size() > 0) begin
      tick(wq.pop_front());
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL stuck_high m=%0d got %h exp %h", m, obs, exp_v);
      end
      if (valid) begin
        last = obs;
        if (stuck && duty == 255 && !locked) saw = 1;
      end
    end
    n_chk++;
    if (!saw) begin
      n_fail++;
      $display("FAIL stuck_high_tmo got none exp duty 255 report");
    end
    n_chk++;
    if (last !== {3'b110, 8'd3, 9'd10}) begin
      n_fail++;
      $display("FAIL stuck_high_recover got %h exp %h", last,
               {3'b110, 8'd3, 9'd10});
    end
  endtask

  task automatic test_saturation();
    int hits = 0;
    do_reset();
    seg(0, 2);
    for (int f = 0; f < 2; f++) begin seg(1, 300); seg(0, 100); end
    seg(1, 5);
    while (wq.size() > 0) begin
      tick(wq.pop_front());
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL saturation m=%0d got %h exp %h", m, obs, exp_v);
      end
      if (valid && duty == 255 && period == 400) hits++;
    end
    n_chk++;
    if (hits !== 2) begin
      n_fail++;
      $display("FAIL saturation_reports got %0d exp 2", hits);
    end
  endtask

  task automatic test_reset_mid();
    int early = 0;
    bit at2 = 0;
    do_reset();
    seg(0, 2);
    for (int f = 0; f < 2; f++) begin seg(1, 100); seg(0, 156); end
    seg(1, 50);
    while (wq.size() > 0) begin
      tick(wq.pop_front());
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL pre_reset m=%0d got %h exp %h", m, obs, exp_v);
      end
    end
    #3;
    rst = 0;
    #1;
    n_chk++;
    if (obs !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_async got %h exp %h", obs, 20'h0);
    end
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    for (int f = 0; f < 3; f++) begin seg(1, 20); seg(0, 80); end
    while (wq.size() > 0) begin
      tick(wq.pop_front());
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL post_reset m=%0d got %h exp %h", m, obs, exp_v);
      end
      if (valid && m < 103) early++;
      if (m == 103) at2 = valid;
    end
    n_chk++;
    if (early !== 0 || !at2) begin
      n_fail++;
      $display("FAIL relock got early=%0d at2=%0d exp 0,1", early, at2);
    end
  endtask

  task automatic test_collision();
    int nrep = 0;
    int ntmo = 0;
    do_reset();
    seg(0, 2); seg(1, 50); seg(0, 461); seg(1, 50); seg(0, 10);
    while (wq.size() > 0) begin
      tick(wq.pop_front());
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL collision m=%0d got %h exp %h", m, obs, exp_v);
      end
      if (valid && stuck) ntmo++;
      if (valid && !stuck && period == 511 && duty == 50) nrep++;
    end
    n_chk++;
    if (nrep !== 1 || ntmo !== 0) begin
      n_fail++;
      $display("FAIL collision_rep got rep=%0d tmo=%0d exp 1,0", nrep, ntmo);
    end
  endtask

  task automatic test_random();
    bit pv = 0;
    do_reset();
    for (int s = 0; s < 30; s++) begin
      seg(1, $urandom_range(300, 1));
      if ($urandom_range(4, 0) == 0) seg(0, $urandom_range(650, 400));
      else seg(0, $urandom_range(300, 1));
    end
    while (wq.size() > 0) begin
      tick(wq.pop_front());
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random m=%0d got %h exp %h", m, obs, exp_v);
      end
      n_chk++;
      if (pv && valid) begin
        n_fail++;
        $display("FAIL valid_b2b m=%0d got 11 exp not both", m);
      end
      pv = valid;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_stuck_low();
    test_stuck_high();
    test_saturation();
    test_reset_mid();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
